// File: rtl/y86_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_fetch_unit_if : CPU-side fetch handshake and instruction-memory bus, rev 1.0
// ----------------------------------------------------------------------------
interface y86_fetch_unit_if;
    logic [31:0] pc;
    logic        pc_req;
    logic [47:0] instr_bytes;
    logic        instr_valid;
    logic        fetch_err;
    logic        fetch_busy;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Environment side: issues fetch requests and answers memory reads
    modport master (
        output pc, pc_req, mem_rdata, mem_ack,
        input  instr_bytes, instr_valid, fetch_err, fetch_busy, mem_addr, mem_rd
    );

    modport slave (
        input  pc, pc_req, mem_rdata, mem_ack,
        output instr_bytes, instr_valid, fetch_err, fetch_busy, mem_addr, mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/y86_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_fetch_unit : 6-byte instruction fetch from 32-bit word memory, rev 1.0
// ----------------------------------------------------------------------------
module y86_fetch_unit #(
    parameter int MAX_WAIT = 16
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    y86_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q;
    logic [31:0] mem_addr_q;
    logic        mem_rd_q;
    logic [1:0]  off_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_q;
    logic [7:0]  wait_q;
    logic [31:0] word0_q, word1_q, word2_q;
    logic [47:0] instr_q;
    logic        valid_q;
    logic        err_q;

    logic [95:0] line_d;
    logic [47:0] instr_d;

    // The word being acked is not yet stored, so splice it in from mem_rdata
    always_comb begin
        line_d = {word2_q, word1_q, word0_q};
        case (cnt_q)
            2'd0:    line_d[31:0]  = bus.mem_rdata;
            2'd1:    line_d[63:32] = bus.mem_rdata;
            default: line_d[95:64] = bus.mem_rdata;
        endcase
        instr_d = '0;
        for (int i = 0; i < 6; i++) begin
            instr_d[47-8*i -: 8] = line_d[8*(int'(off_q)+i) +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            off_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            wait_q     <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
            word2_q    <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.pc_req) begin
                        mem_addr_q <= {bus.pc[31:2], 2'b00};
                        off_q      <= bus.pc[1:0];
                        last_q     <= (bus.pc[1:0] == 2'd3) ? 2'd2 : 2'd1;
                        cnt_q      <= '0;
                        wait_q     <= '0;
                        mem_rd_q   <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        case (cnt_q)
                            2'd0:    word0_q <= bus.mem_rdata;
                            2'd1:    word1_q <= bus.mem_rdata;
                            default: word2_q <= bus.mem_rdata;
                        endcase
                        wait_q <= '0;
                        if (cnt_q == last_q) begin
                            mem_rd_q <= 1'b0;
                            instr_q  <= instr_d;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q      <= cnt_q + 2'd1;
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end
                    end else if (wait_q == c_WAIT_LAST) begin
                        mem_rd_q <= 1'b0;
                        instr_q  <= '0;
                        valid_q  <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.instr_bytes = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.fetch_busy  = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_y86_fetch_unit : randomized fetch stimulus against a byte-level memory model, rev 1.0
// ----------------------------------------------------------------------------
module tb_y86_fetch_unit;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    y86_fetch_unit_if bus();

    y86_fetch_unit #(.MAX_WAIT(MAX_WAIT)) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed memory: explicit overrides, otherwise a hash of the address
    logic [7:0] mem_ovr [logic [31:0]];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = a * 32'd2654435761;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_ovr[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Memory responder: word k of a fetch is acked after tgt[k] wait cycles
    int          tgt [3];
    int          widx = 0;
    int          wcnt = 0;
    bit          stray_ack = 1'b0;
    logic [31:0] acked_q [$];

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.pc        = '0;
        bus.pc_req    = 1'b0;
    end

    always @(negedge clk) begin
        if (stray_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hDEADBEEF;
        end else if (bus.mem_rd !== 1'b1) begin
            bus.mem_ack = 1'b0;
            widx = 0;
            wcnt = 0;
        end else begin
            if (bus.mem_ack) begin
                widx++;
                wcnt = 0;
            end
            if (widx < 3 && wcnt == tgt[widx]) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                acked_q.push_back(bus.mem_addr);
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    task automatic run_fetch(input logic [31:0] a, input int w0, input int w1, input int w2,
                             input bit hold_req);
        int          waits [3];
        int          nw, lat, cyc, rd_cnt, guard;
        bit          err, seen;
        logic [31:0] base, addr;
        logic [47:0] exp_bytes;
        logic [31:0] exp_addrs [$];

        waits[0] = w0; waits[1] = w1; waits[2] = w2;
        guard = 0;
        while (bus.fetch_busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end

        base = {a[31:2], 2'b00};
        nw   = (a[1:0] == 2'd3) ? 3 : 2;
        lat  = 0;
        err  = 1'b0;
        for (int i = 0; i < nw; i++) begin
            if (waits[i] >= MAX_WAIT) begin
                lat += MAX_WAIT;
                err = 1'b1;
                break;
            end
            lat += waits[i] + 1;
            addr = base + 32'(4 * i);
            exp_addrs.push_back(addr);
        end
        exp_bytes = '0;
        if (!err) begin
            for (int i = 0; i < 6; i++) exp_bytes = {exp_bytes[39:0], mem_byte(a + 32'(i))};
        end

        for (int i = 0; i < 3; i++) tgt[i] = waits[i];
        acked_q.delete();
        @(negedge clk);
        bus.pc     = a;
        bus.pc_req = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_accept", 64'(bus.fetch_busy), 64'd1);
        if (!hold_req) bus.pc_req = 1'b0;

        cyc    = 0;
        rd_cnt = 0;
        seen   = 1'b0;
        while (cyc < 40) begin
            if (bus.mem_rd) rd_cnt++;
            if (hold_req) bus.pc = $urandom;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("rd_cycles", 64'(rd_cnt), 64'(lat));
        check("instr_bytes", 64'(bus.instr_bytes), 64'(exp_bytes));
        check("fetch_err", 64'(bus.fetch_err), 64'(err));
        check("n_words_read", 64'(acked_q.size()), 64'(exp_addrs.size()));
        for (int i = 0; i < exp_addrs.size() && i < acked_q.size(); i++)
            check("mem_addr", 64'(acked_q[i]), 64'(exp_addrs[i]));

        @(posedge clk);
        #1;
        check("valid_strobe_len", 64'(bus.instr_valid), 64'd0);
        check("err_strobe_len", 64'(bus.fetch_err), 64'd0);
        check("idle_after_done", 64'(bus.fetch_busy), 64'd0);
        check("bytes_hold", 64'(bus.instr_bytes), 64'(exp_bytes));
        if (hold_req) begin
            @(posedge clk);
            #1;
            check("held_req_accepted_in_idle", 64'(bus.fetch_busy), 64'd1);
            bus.pc_req = 1'b0;
            guard = 0;
            while (bus.fetch_busy && guard < 40) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("held_fetch_finished", 64'(bus.fetch_busy), 64'd0);
        end
    endtask

    initial begin
        int w [3];

        for (int i = 0; i < 3; i++) tgt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_bytes", 64'(bus.instr_bytes), 64'd0);
        check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
        check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_busy", 64'(bus.fetch_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        run_fetch(32'h100, 0, 0, 0, 1'b0);
        check("aligned_literal", 64'(bus.instr_bytes), 64'h112233445566);

        set_word(32'h200, 32'hDDCCBBAA);
        set_word(32'h204, 32'h44332211);
        set_word(32'h208, 32'h88776655);
        run_fetch(32'h203, 2, 2, 2, 1'b0);
        check("offset3_literal", 64'(bus.instr_bytes), 64'hDD1122334455);

        run_fetch(32'h40, 99, 0, 0, 1'b0);
        run_fetch(32'hFFFFFFFE, 1, 0, 0, 1'b0);

        // Reset while the second word is outstanding
        tgt[0] = 0; tgt[1] = 3; tgt[2] = 0;
        @(negedge clk);
        bus.pc     = 32'h100;
        bus.pc_req = 1'b1;
        @(posedge clk);
        #1;
        bus.pc_req = 1'b0;
        @(posedge clk);
        #1;
        check("mid_second_word", 64'(bus.mem_addr), 64'h104);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("midrst_valid", 64'(bus.instr_valid), 64'd0);
        check("midrst_bytes", 64'(bus.instr_bytes), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(posedge clk);
        #1;
        check("stray_ack_busy", 64'(bus.fetch_busy), 64'd0);
        check("stray_ack_valid", 64'(bus.instr_valid), 64'd0);
        run_fetch(32'h0, 0, 0, 0, 1'b0);

        run_fetch(32'h300, 1, 0, 1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++)
                w[k] = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
            run_fetch($urandom, w[0], w[1], w[2], ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/y86_fetch_unit.md
Name: y86_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the y86_cpu datapath.
- Takes the CPU's current PC and reads the 6 instruction bytes starting at that byte address from a 32-bit word-wide instruction memory, using a request/acknowledge handshake.
- Presents the 6 bytes as one 48-bit instruction word with a valid strobe.
- Converts a memory timeout into an all-zero (halt) instruction plus an error flag, so the CPU stops cleanly.

Parameters:
- MAX_WAIT, 16: cycles to wait for mem_ack on a single word request before declaring a fetch error (range 1..255).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- pc  in  32  byte address of the instruction to fetch; sampled only when a request is accepted.
- pc_req  in  1  fetch request; accepted only in IDLE.
- instr_bytes  out  48  fetched bytes: [47:40]=byte@pc, [39:32]=byte@pc+1, …, [7:0]=byte@pc+5.
- instr_valid  out  1  one-cycle strobe; instr_bytes is valid in that cycle.
- fetch_err  out  1  one-cycle strobe coincident with instr_valid when a timeout occurred.
- fetch_busy  out  1  high in every state except IDLE.
- mem_addr  out  32  word-aligned byte address; [1:0] always 2'b00.
- mem_rd  out  1  memory read request.
- mem_rdata  in  32  read data, little-endian: [7:0]=byte@mem_addr, [31:24]=byte@mem_addr+3.
- mem_ack  in  1  read data valid; sampled at the same edge as mem_rdata.

Behaviour:
- Reset:
  - CLK and RESET: one clock; reset is synchronous and active-high.
  - RESET high at a rising edge forces state IDLE; instr_bytes=0, instr_valid=0, fetch_err=0, mem_rd=0, mem_addr=0, counters=0.
  - Reset takes priority over every other event, including mid-transaction; an outstanding mem_ack after reset is ignored.
- State machine: IDLE, REQ, DONE.
- IDLE:
  - mem_rd=0.
  - On pc_req=1 at an edge: latch base={pc[31:2],2'b00}, off=pc[1:0], nwords=(off==3)?3:2, cnt=0, wait=0; go to REQ.
- REQ:
  - mem_rd=1 and mem_addr=base+4*cnt (modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000).
  - Address and mem_rd stay stable until ack.
  - mem_ack may be high in the first REQ cycle (zero-wait memory).
  - On ack: word[cnt]<=mem_rdata, wait<=0.
    - If cnt==nwords-1, go to DONE.
    - Otherwise cnt<=cnt+1 and stay in REQ; mem_rd stays high with the next address.
  - No ack: wait<=wait+1.
  - If wait==MAX_WAIT-1 with no ack: set err flag, zero the assembled bytes, go to DONE.
- DONE:
  - instr_valid=1 for exactly this cycle; fetch_err=err.
  - instr_bytes = bytes off..off+5 of the concatenation {word2,word1,word0} in little-endian order, or 0 on error.
  - mem_rd=0; next state IDLE.
  - instr_bytes holds its value after DONE until the next DONE or reset.
- pc_req while busy is ignored; it is neither queued nor latched. pc changes while busy have no effect.
- Latency with zero-wait memory, request accepted at edge 0:
  - 2-word fetch: instr_valid high in the cycle after edge 2 (3 cycles from request).
  - 3-word fetch: 4 cycles from request.
  - Each wait cycle per word adds 1.
- Back-to-back: pc_req may be asserted during DONE, but it is only accepted in the following IDLE cycle. Minimum period is therefore 4 cycles (2-word fetch).
- An error on any word ends the fetch immediately; remaining words are not requested.

Test Plan:
- Aligned fetch, zero-wait: pc=0x100, word@0x100=0x44332211, word@0x104=0x88776655 → mem_addr 0x100 then 0x104; instr_bytes=0x112233445566; instr_valid 3 cycles after request; fetch_err=0.
- Offset 3 with wait states: pc=0x203, words @0x200/0x204/0x208 = 0xDDCCBBAA/0x44332211/0x88776655, each acked after 2 wait cycles → three requests; instr_bytes=0xDD1122334455; valid 10 cycles after request.
- Timeout: pc=0x40 with MAX_WAIT=4 and mem_ack never asserted → mem_rd high for 4 cycles, then instr_valid=1, fetch_err=1, instr_bytes=0; FSM back in IDLE.
- Wrap: pc=0xFFFFFFFE → mem_addr 0xFFFFFFFC then 0x00000000; bytes assembled from both words in order.
- Reset mid-fetch: RESET during the second REQ word → next cycle mem_rd=0, instr_valid=0, instr_bytes=0; a later ack is ignored; a new request at pc=0x0 completes normally.
- Busy request: pc_req held high continuously → requests accepted only in IDLE; no second fetch starts before instr_valid; pc changes mid-fetch do not alter the result.
